// File: rtl/west_feeder_pkg.sv
// Shared types and instruction encodings for the west-edge feeder of the systolic array.
package west_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] INST_BUBBLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD   = 2'b01;
  localparam logic [1:0] INST_EXEC_WS = 2'b10;
  localparam logic [1:0] INST_EXEC_OS = 2'b01;

  // OS rows only ever execute; WS rows distinguish kernel load from execute.
  function automatic logic [1:0] encode_inst(input logic mode, input logic op);
    if (!mode) return INST_EXEC_OS;
    return op ? INST_EXEC_WS : INST_KLOAD;
  endfunction

endpackage

// File: rtl/west_feeder_skew_line.sv
// Per-lane delay line: d register stages of w bits, d=0 is a plain wire.
module skew_line #(
  parameter int d = 1,
  parameter int w = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] din,
  output logic [w-1:0] dout
);

  if (d == 0) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout = din;
  end else begin : g_shift
    logic [w-1:0] sr_q [0:d-1];
    logic [w-1:0] sr_d [0:d-1];

    always_comb begin
      sr_d[0] = din;
      for (int i = 1; i < d; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < d; i++) sr_q[i] <= '0;
      end else begin
        for (int i = 0; i < d; i++) sr_q[i] <= sr_d[i];
      end
    end

    assign dout = sr_q[d-1];
  end

endmodule

// File: rtl/west_feeder.sv
// West-edge feeder: turns buffered vectors into diagonally skewed per-row data/instruction lanes.
// Optional stall counter output is enabled by defining WEST_FEEDER_STATS_EN.
module west_feeder
  import west_feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [len_bw-1:0]   cmd_len,
  input  logic [row*bw-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_w,
  output logic                busy,
  output logic                done
`ifdef WEST_FEEDER_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int DCW = (row > 2) ? $clog2(row - 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((row > 1) ? row - 2 : 0);

  state_t              state_q, state_d;
  logic [len_bw-1:0]   rem_q, rem_d;
  logic                mode_q, mode_d;
  logic                op_q, op_d;
  logic [DCW-1:0]      drain_q, drain_d;
  logic [row*bw-1:0]   stage_data_q, stage_data_d;
  logic [1:0]          stage_inst_q, stage_inst_d;
  logic                accept;
  logic                handshake;

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == STREAM) && (rem_q != '0);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign handshake = in_valid && in_ready;

  // Stall cycles still load the row-0 stage, with a bubble, so the skew stays aligned.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    op_d         = op_q;
    drain_d      = drain_q;
    stage_data_d = handshake ? in_data : '0;
    stage_inst_d = handshake ? encode_inst(mode_q, op_q) : INST_BUBBLE;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = mode;
          op_d    = cmd_op;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(len_bw-1){1'b0}}, 1'b1}) begin
            state_d = (row > 1) ? DRAIN : DONE;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      mode_q       <= 1'b0;
      op_q         <= 1'b0;
      drain_q      <= '0;
      stage_data_q <= '0;
      stage_inst_q <= INST_BUBBLE;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      op_q         <= op_d;
      drain_q      <= drain_d;
      stage_data_q <= stage_data_d;
      stage_inst_q <= stage_inst_d;
    end
  end

  // Lane r adds r more stages behind the shared row-0 register.
  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [bw+1:0] lane_out;

    skew_line #(
      .d(r),
      .w(bw + 2)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .din  ({stage_inst_q, stage_data_q[r*bw +: bw]}),
      .dout (lane_out)
    );

    assign out_w[r*bw +: bw] = lane_out[bw-1:0];
    assign inst_w[2*r +: 2]  = lane_out[bw+1:bw];
  end

`ifdef WEST_FEEDER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (in_ready && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_west_feeder.sv
// Directed bench for west_feeder (row=8, bw=4): skew timing, encodings, stalls, busy/done and reset.
module tb_west_feeder;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int LB  = 8;

  logic              clk;
  logic              reset;
  logic              mode;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [LB-1:0]     cmd_len;
  logic [ROW*BW-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ROW*BW-1:0] out_w;
  logic [ROW*2-1:0]  inst_w;
  logic              busy;
  logic              done;
`ifdef WEST_FEEDER_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  west_feeder #(.bw(BW), .row(ROW), .len_bw(LB)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_w    (out_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done)
`ifdef WEST_FEEDER_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic m, input logic op, input logic [LB-1:0] len);
    mode      = m;
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [BW-1:0] lane_d(input int r);
    return out_w[r*BW +: BW];
  endfunction

  function automatic logic [1:0] lane_i(input int r);
    return inst_w[2*r +: 2];
  endfunction

  int          busy_cycles;
  int          j;
  logic        saw_done;
  logic [31:0] ew;
  logic [15:0] ei;
  int          data_tab [5] = '{1, 0, 0, 2, 3};
  int          valid_tab[5] = '{1, 0, 0, 1, 1};
  int          probe    [3] = '{0, 3, 7};

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_len   = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();

    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_out_w", out_w, 0);
    check_output("rst_inst_w", inst_w, 0);

    // WS kernel load of a single vector: one nibble walks down the diagonal.
    in_data  = 32'h87654321;
    in_valid = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'd1);
    check_output("ws_load_in_ready", in_ready, 1);
    check_output("ws_load_busy", busy, 1);
    step();
    in_valid = 1'b0;
    check_output("ws_load_lane0_data", out_w, 32'h1);
    check_output("ws_load_lane0_inst", inst_w, 16'h1);
    check_output("ws_load_in_ready_after", in_ready, 0);
    for (int k = 1; k < ROW; k++) begin
      step();
      ew = 32'(k + 1) << (4 * k);
      ei = 16'h1 << (2 * k);
      check_output($sformatf("ws_load_lane%0d_data", k), out_w, ew);
      check_output($sformatf("ws_load_lane%0d_inst", k), inst_w, ei);
      check_output($sformatf("ws_load_done_e%0d", k), done, (k == ROW - 1));
    end
    step();
    check_output("ws_load_done_end", done, 0);
    check_output("ws_load_busy_end", busy, 0);
    check_output("ws_load_out_end", out_w, 0);
    check_output("ws_load_cmd_ready_end", cmd_ready, 1);

    // WS execute, four back-to-back vectors.
    in_data  = 32'h11111111;
    in_valid = 1'b1;
    apply_stimulus(1'b1, 1'b1, 8'd4);
    busy_cycles = 1;
    for (int e = 1; e <= 20; e++) begin
      in_valid = (e <= 4);
      in_data  = (e <= 4) ? 32'h11111111 * 32'(e) : 32'h0;
      step();
      if (!busy) break;
      busy_cycles++;
      if (e >= 4 && e <= 8) begin
        check_output($sformatf("ws_exec_lane3_data_e%0d", e), lane_d(3), (e <= 7) ? e - 3 : 0);
        check_output($sformatf("ws_exec_lane3_inst_e%0d", e), lane_i(3), (e <= 7) ? 2'b10 : 2'b00);
      end
      if (e == 11) check_output("ws_exec_done", done, 1);
    end
    in_valid = 1'b0;
    check_output("ws_exec_busy_cycles", busy_cycles, 12);

    // OS with a two-cycle input gap; mode flips after accept and must not matter.
    apply_stimulus(1'b0, 1'b1, 8'd3);
    mode = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e <= 5) begin
        in_valid = valid_tab[e-1][0];
        in_data  = 32'h11111111 * 32'(data_tab[e-1]);
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      step();
      if (!busy) break;
      if (e == 1 || e == 2) check_output($sformatf("os_stall_in_ready_e%0d", e), in_ready, 1);
      for (int p = 0; p < 3; p++) begin
        j = e - 1 - probe[p];
        if (j >= 0 && j < 5) begin
          check_output($sformatf("os_lane%0d_data_j%0d", probe[p], j), lane_d(probe[p]), data_tab[j]);
          check_output($sformatf("os_lane%0d_inst_j%0d", probe[p], j), lane_i(probe[p]),
                       (data_tab[j] != 0) ? 2'b01 : 2'b00);
        end
      end
      if (e == 12) check_output("os_done", done, 1);
    end
    mode = 1'b0;
`ifdef WEST_FEEDER_STATS_EN
    check_output("os_stall_cnt", stall_cnt, 2);
`endif

    // Zero-length command: straight to DONE, nothing consumed.
    in_data  = 32'hFFFFFFFF;
    in_valid = 1'b1;
    apply_stimulus(1'b1, 1'b1, 8'd0);
    check_output("zero_done", done, 1);
    check_output("zero_busy", busy, 1);
    check_output("zero_cmd_ready", cmd_ready, 0);
    check_output("zero_in_ready", in_ready, 0);
    check_output("zero_inst", inst_w, 0);
    step();
    check_output("zero_done_after", done, 0);
    check_output("zero_busy_after", busy, 0);
    check_output("zero_inst_after", inst_w, 0);
    check_output("zero_out_after", out_w, 0);

    // A command held on cmd_valid while busy is neither taken nor queued.
    in_data  = 32'h55555555;
    apply_stimulus(1'b1, 1'b0, 8'd2);
    cmd_valid   = 1'b1;
    cmd_len     = 8'd5;
    busy_cycles = 1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!busy) break;
      busy_cycles++;
      check_output($sformatf("hold_cmd_ready_e%0d", e), cmd_ready, 0);
      if (done) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    check_output("hold_busy_cycles", busy_cycles, 10);
    step();
    check_output("hold_not_queued", busy, 0);

    // Asynchronous reset in the middle of DRAIN.
    in_data  = 32'hAAAAAAAA;
    in_valid = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    check_output("drain_lane2_inst", inst_w, 16'h1 << 4);
    #2 reset = 1'b1;
    #1;
    check_output("arst_out_w", out_w, 0);
    check_output("arst_inst_w", inst_w, 0);
    check_output("arst_busy", busy, 0);
    check_output("arst_cmd_ready", cmd_ready, 1);
    check_output("arst_done", done, 0);
    #2 reset = 1'b0;
    saw_done = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      saw_done = saw_done | done;
    end
    check_output("arst_no_done", saw_done, 0);
    check_output("arst_cmd_ready_after", cmd_ready, 1);
    check_output("arst_out_after", out_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
